// File: rtl/keccak_padder_p_if.sv
// Word-in / block-out handshake bundle between a message source and the padder.
interface keccak_padder_p_if #(
  parameter int unsigned W        = 64,
  parameter int unsigned RATE_MAX = 1152
);
  localparam int unsigned BW = $clog2(W / 8);

  logic [W-1:0]        in;
  logic                in_valid;
  logic                is_last;
  logic [BW-1:0]       byte_num;
  logic [1:0]          mode;
  logic                ack;
  logic [RATE_MAX-1:0] out;
  logic                out_ready;
  logic                out_last;
  logic                f_ack;

  // Source / permutation side.
  modport master (
    output in, in_valid, is_last, byte_num, mode, f_ack,
    input  ack, out, out_ready, out_last
  );

  // Padder side.
  modport slave (
    input  in, in_valid, is_last, byte_num, mode, f_ack,
    output ack, out, out_ready, out_last
  );
endinterface

// File: rtl/keccak_padder_p.sv
// Absorb-side padder: packs W-bit words into a rate block, applies pad10*1
// with a domain byte, and holds the block until the permutation acks it.
module keccak_padder_p #(
  parameter int unsigned W        = 64,
  parameter logic [7:0]  DOMAIN   = 8'h06,
  parameter int unsigned RATE_MAX = 1152
) (
  input logic              clk,
  input logic              rst,
  keccak_padder_p_if.slave bus
);

  localparam int unsigned NB  = W / 8;
  localparam int unsigned BW  = $clog2(NB);
  localparam int unsigned CW  = 6;
  localparam int unsigned RBW = 11;
  localparam int unsigned IW  = $clog2(RATE_MAX);

  typedef enum logic {ABSORB, FULL} state_t;

  state_t              state;
  logic [CW-1:0]       cnt;
  logic [1:0]          mode_q;
  logic                in_msg;
  logic [RATE_MAX-1:0] blk_q;
  logic                ack_q;
  logic                ready_q;
  logic                last_q;

  logic [1:0]          mode_eff;
  logic [RBW-1:0]      rate_bits;
  logic [CW-1:0]       r_words;
  logic [IW-1:0]       base;
  logic [IW-1:0]       pad_idx;
  logic [W-1:0]        last_word;
  logic                accept;

  // Rate selection: a fresh message uses the live mode, otherwise the latched one.
  always_comb begin
    mode_eff = (cnt == '0 && !in_msg) ? bus.mode : mode_q;
    case (mode_eff)
      2'b00:   rate_bits = RBW'(1152);
      2'b01:   rate_bits = RBW'(1088);
      2'b10:   rate_bits = RBW'(832);
      default: rate_bits = RBW'(576);
    endcase
    r_words = CW'(rate_bits / RBW'(W));
    pad_idx = IW'(rate_bits - RBW'(1));
    base    = IW'(cnt) * IW'(W);
    accept  = bus.in_valid & ack_q;
  end

  // Final word: message bytes below byte_num, domain byte at byte_num, zeros above.
  always_comb begin
    last_word = '0;
    for (int k = 0; k < NB; k++) begin
      if (BW'(k) < bus.byte_num)
        last_word[8*k +: 8] = bus.in[8*k +: 8];
      else if (BW'(k) == bus.byte_num)
        last_word[8*k +: 8] = DOMAIN;
    end
  end

  // Absorb / hold state machine with registered handshake outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ABSORB;
      cnt     <= '0;
      mode_q  <= 2'b00;
      in_msg  <= 1'b0;
      blk_q   <= '0;
      ack_q   <= 1'b1;
      ready_q <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      case (state)
        ABSORB: begin
          if (accept) begin
            if (cnt == '0 && !in_msg)
              mode_q <= bus.mode;
            in_msg <= 1'b1;
            if (bus.is_last) begin
              blk_q[base +: W] <= last_word;
              // Closing pad bit; may land in the same byte as the domain byte.
              blk_q[pad_idx]   <= 1'b1;
              state            <= FULL;
              ack_q            <= 1'b0;
              ready_q          <= 1'b1;
              last_q           <= 1'b1;
            end else begin
              blk_q[base +: W] <= bus.in;
              cnt              <= cnt + CW'(1);
              if (cnt + CW'(1) == r_words) begin
                state   <= FULL;
                ack_q   <= 1'b0;
                ready_q <= 1'b1;
                last_q  <= 1'b0;
              end
            end
          end
        end
        FULL: begin
          if (bus.f_ack) begin
            blk_q   <= '0;
            cnt     <= '0;
            state   <= ABSORB;
            ack_q   <= 1'b1;
            ready_q <= 1'b0;
            last_q  <= 1'b0;
            if (last_q)
              in_msg <= 1'b0;
          end
        end
        default: state <= ABSORB;
      endcase
    end
  end

  assign bus.ack       = ack_q;
  assign bus.out       = blk_q;
  assign bus.out_ready = ready_q;
  assign bus.out_last  = last_q;

endmodule

// File: tb/tb_keccak_padder_p.sv
// Directed bench for keccak_padder_p at W=64 and W=32.
module tb_keccak_padder_p;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_err;
  logic [1151:0] exp;

  keccak_padder_p_if #(.W(64), .RATE_MAX(1152)) bus64 ();
  keccak_padder_p_if #(.W(32), .RATE_MAX(1152)) bus32 ();

  keccak_padder_p #(.W(64), .DOMAIN(8'h06), .RATE_MAX(1152)) dut64 (
    .clk (clk),
    .rst (rst),
    .bus (bus64)
  );

  keccak_padder_p #(.W(32), .DOMAIN(8'h06), .RATE_MAX(1152)) dut32 (
    .clk (clk),
    .rst (rst),
    .bus (bus32)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [1151:0] obs, input logic [1151:0] want);
    n_cmp++;
    assert (obs === want) else begin
      n_err++;
      $error("FAIL %s observed(lo128)=%h expected(lo128)=%h differing_bits=%0d",
             tag, obs[127:0], want[127:0], $countones(obs ^ want));
    end
  endtask

  task automatic send64(input logic [63:0] d, input logic last, input logic [2:0] bn,
                        input logic [1:0] m);
    @(negedge clk);
    bus64.in       = d;
    bus64.in_valid = 1'b1;
    bus64.is_last  = last;
    bus64.byte_num = bn;
    bus64.mode     = m;
    chk("ack64_before_send", 1152'(bus64.ack), 1152'(1));
    @(posedge clk);
    #1;
    bus64.in_valid = 1'b0;
    bus64.is_last  = 1'b0;
  endtask

  task automatic send32(input logic [31:0] d, input logic last, input logic [1:0] bn,
                        input logic [1:0] m);
    @(negedge clk);
    bus32.in       = d;
    bus32.in_valid = 1'b1;
    bus32.is_last  = last;
    bus32.byte_num = bn;
    bus32.mode     = m;
    chk("ack32_before_send", 1152'(bus32.ack), 1152'(1));
    @(posedge clk);
    #1;
    bus32.in_valid = 1'b0;
    bus32.is_last  = 1'b0;
  endtask

  task automatic fack64();
    @(negedge clk);
    bus64.f_ack = 1'b1;
    @(posedge clk);
    #1;
    bus64.f_ack = 1'b0;
  endtask

  task automatic fack32();
    @(negedge clk);
    bus32.f_ack = 1'b1;
    @(posedge clk);
    #1;
    bus32.f_ack = 1'b0;
  endtask

  // Time bound so a stuck run still ends.
  initial begin
    #200000;
    $display("FAIL timeout reached observed=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst = 1'b1;
    bus64.in = '0; bus64.in_valid = 1'b0; bus64.is_last = 1'b0;
    bus64.byte_num = '0; bus64.mode = 2'b00; bus64.f_ack = 1'b0;
    bus32.in = '0; bus32.in_valid = 1'b0; bus32.is_last = 1'b0;
    bus32.byte_num = '0; bus32.mode = 2'b00; bus32.f_ack = 1'b0;

    // Reset held two cycles.
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("rst_out", bus64.out, '0);
    chk("rst_ready", 1152'(bus64.out_ready), 1152'(0));
    chk("rst_last", 1152'(bus64.out_last), 1152'(0));
    chk("rst_ack", 1152'(bus64.ack), 1152'(1));
    @(negedge clk);
    rst = 1'b0;

    // Reset mid-message, then an empty message gives a padding-only block.
    for (int i = 0; i < 5; i++) send64(64'h1111_0000 + 64'(i), 1'b0, 3'd0, 2'b01);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_out", bus64.out, '0);
    chk("midrst_ready", 1152'(bus64.out_ready), 1152'(0));
    send64(64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 3'd0, 2'b01);
    exp = '0;
    exp[7:0] = 8'h06;
    exp[1087:1080] = 8'h80;
    chk("empty_out", bus64.out, exp);
    chk("empty_ready", 1152'(bus64.out_ready), 1152'(1));
    chk("empty_last", 1152'(bus64.out_last), 1152'(1));
    chk("empty_ack", 1152'(bus64.ack), 1152'(0));
    @(posedge clk);
    #1;
    chk("empty_hold_ready", 1152'(bus64.out_ready), 1152'(1));
    chk("empty_hold_ack", 1152'(bus64.ack), 1152'(0));
    chk("empty_hold_out", bus64.out, exp);
    fack64();
    chk("fack_out_clr", bus64.out, '0);
    chk("fack_ready", 1152'(bus64.out_ready), 1152'(0));
    chk("fack_last", 1152'(bus64.out_last), 1152'(0));
    chk("fack_ack", 1152'(bus64.ack), 1152'(1));

    // Partial last word, three message bytes.
    send64(64'h0000_0000_00AA_BBCC, 1'b1, 3'd3, 2'b01);
    exp = '0;
    exp[31:0] = 32'h06AA_BBCC;
    exp[1087:1080] = 8'h80;
    chk("partial_out", bus64.out, exp);
    chk("partial_last", 1152'(bus64.out_last), 1152'(1));
    fack64();

    // f_ack while absorbing is ignored.
    send64(64'h0123_4567_89AB_CDEF, 1'b0, 3'd0, 2'b01);
    fack64();
    exp = '0;
    exp[63:0] = 64'h0123_4567_89AB_CDEF;
    chk("absorb_fack_ignored", bus64.out, exp);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Multi-block: 17 full words fill the 1088-bit rate.
    exp = '0;
    for (int i = 0; i < 17; i++) begin
      send64(64'hA5A5_0000_0000_0000 + 64'(i), 1'b0, 3'd0, 2'b01);
      exp[i*64 +: 64] = 64'hA5A5_0000_0000_0000 + 64'(i);
      if (i == 15) chk("mb_not_ready_16", 1152'(bus64.out_ready), 1152'(0));
    end
    chk("mb_blk1_out", bus64.out, exp);
    chk("mb_blk1_ready", 1152'(bus64.out_ready), 1152'(1));
    chk("mb_blk1_last", 1152'(bus64.out_last), 1152'(0));
    chk("mb_blk1_ack", 1152'(bus64.ack), 1152'(0));

    // f_ack and in_valid together: word waits one cycle.
    @(negedge clk);
    bus64.f_ack    = 1'b1;
    bus64.in_valid = 1'b1;
    bus64.is_last  = 1'b1;
    bus64.byte_num = 3'd0;
    bus64.in       = 64'hDEAD_BEEF_DEAD_BEEF;
    bus64.mode     = 2'b00;
    @(posedge clk);
    #1;
    chk("collide_not_taken", 1152'(bus64.out_ready), 1152'(0));
    chk("collide_ack", 1152'(bus64.ack), 1152'(1));
    chk("collide_out_clr", bus64.out, '0);
    @(negedge clk);
    bus64.f_ack = 1'b0;
    @(posedge clk);
    #1;
    bus64.in_valid = 1'b0;
    bus64.is_last  = 1'b0;
    exp = '0;
    exp[7:0] = 8'h06;
    exp[1087:1080] = 8'h80;
    chk("mb_blk2_out", bus64.out, exp);
    chk("mb_blk2_ready", 1152'(bus64.out_ready), 1152'(1));
    chk("mb_blk2_last", 1152'(bus64.out_last), 1152'(1));
    fack64();

    // Merge boundary, 576-bit rate: domain and pad bit share the top byte.
    exp = '0;
    for (int i = 0; i < 8; i++) begin
      send64(64'h5A00_0000_0000_0000 + 64'(i), 1'b0, 3'd0, 2'b11);
      exp[i*64 +: 64] = 64'h5A00_0000_0000_0000 + 64'(i);
    end
    chk("merge_not_ready", 1152'(bus64.out_ready), 1152'(0));
    send64(64'h0011_2233_4455_6677, 1'b1, 3'd7, 2'b11);
    exp[575:512] = 64'h8611_2233_4455_6677;
    chk("merge_out", bus64.out, exp);
    chk("merge_last", 1152'(bus64.out_last), 1152'(1));
    fack64();

    // W=32: mode latched at 832 bits despite a switch to 00 after word 1.
    exp = '0;
    for (int i = 0; i < 26; i++) begin
      send32(32'hC0DE_0000 + 32'(i), 1'b0, 2'd0, (i == 0) ? 2'b10 : 2'b00);
      exp[i*32 +: 32] = 32'hC0DE_0000 + 32'(i);
      if (i == 24) chk("w32_not_ready_25", 1152'(bus32.out_ready), 1152'(0));
    end
    chk("w32_blk_out", bus32.out, exp);
    chk("w32_blk_ready", 1152'(bus32.out_ready), 1152'(1));
    chk("w32_blk_last", 1152'(bus32.out_last), 1152'(0));
    fack32();
    // Closing word of the same message still uses the latched 832-bit rate.
    send32(32'h1234_5678, 1'b1, 2'd0, 2'b00);
    exp = '0;
    exp[7:0] = 8'h06;
    exp[831:824] = 8'h80;
    chk("w32_pad_out", bus32.out, exp);
    chk("w32_pad_last", 1152'(bus32.out_last), 1152'(1));
    fack32();

    // New message in mode 00 takes 36 words.
    exp = '0;
    for (int i = 0; i < 36; i++) begin
      send32(32'hBEEF_0000 + 32'(i), 1'b0, 2'd0, 2'b00);
      exp[i*32 +: 32] = 32'hBEEF_0000 + 32'(i);
      if (i == 34) chk("w32_m0_not_ready_35", 1152'(bus32.out_ready), 1152'(0));
    end
    chk("w32_m0_out", bus32.out, exp);
    chk("w32_m0_ready", 1152'(bus32.out_ready), 1152'(1));
    chk("w32_m0_last", 1152'(bus32.out_last), 1152'(0));
    fack32();
    chk("w32_m0_ack_after", 1152'(bus32.ack), 1152'(1));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/keccak_padder_p.md
Name: keccak_padder_p

Overview:
- Parametrised absorb-side input padder for the keccak core.
- Packs W-bit message words into one rate block, applies multi-rate pad10*1 with a configurable domain byte, and presents the full block to the permutation with a ready/ack handshake.
- Generalises the fixed 64-bit padder: selectable word width, per-message rate mode, partial last-word byte count, and a final-block flag.

Parameters:
- W, 64, input word width in bits; legal values 32 or 64.
- DOMAIN, 8'h06, domain-separation byte (8'h06 SHA3, 8'h1F SHAKE).
- RATE_MAX, 1152, output bus width; the largest supported rate.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- in  in  W  message word; byte k occupies bits [8k+7:8k]
- in_valid  in  1  in carries a word this cycle
- is_last  in  1  this word ends the message
- byte_num  in  $clog2(W/8)  valid bytes in the last word, 0..W/8-1; ignored unless is_last
- mode  in  2  rate select: 00=1152, 01=1088, 10=832, 11=576 bits
- ack  out  1  word accepted this cycle when in_valid & ack
- out  out  RATE_MAX  padded block; word i at bits [W*i+W-1:W*i]; bits at or above the rate are 0
- out_ready  out  1  block complete, held until f_ack
- out_last  out  1  block is the final block of the message; valid with out_ready
- f_ack  in  1  permutation consumed the block

Behaviour:
- Reset: out=0, out_ready=0, out_last=0, ack=1, word counter=0, state=ABSORB, mode register=00.
- Reset mid-operation discards any partial or pending block.
- States:
  - ABSORB: ack=1.
  - FULL: ack=0, out_ready=1.
- Rate words: R = rate/W, i.e. 18/17/13/9 words for W=64 and 36/34/26/18 for W=32.
- Mode latch: mode is captured when the first word of a message is accepted (counter=0 and no message in progress). Changes to mode mid-message are ignored until after the final block's f_ack.
- ABSORB, in_valid & !is_last: write in to word[cnt], cnt+1. When cnt reaches R, go to FULL with out_last=0.
- ABSORB, in_valid & is_last:
  - Bytes 0..byte_num-1 are taken from in; byte byte_num = DOMAIN; higher bytes of that word = 0.
  - Remaining words of the block stay 0 (the buffer is cleared after each f_ack).
  - Bit rate-1 is ORed with 1, i.e. top byte |= 8'h80.
  - If the last word is word R-1 and byte_num=W/8-1, the domain byte and 0x80 merge into one byte, giving 0x86 for SHA3.
  - Go to FULL with out_last=1. There are no zero-fill cycles.
- Full last word: the caller sends the full word with is_last=0, then a separate is_last word with byte_num=0. The `in` data of that second word is ignored.
  - If that is_last word arrives when cnt=0, the whole block is padding only.
- Latency: out_ready rises on the cycle after the completing word is accepted.
- FULL:
  - out is stable; in_valid is not accepted (ack=0).
  - f_ack causes, next cycle: buffer=0, cnt=0, out_ready=0, out_last=0, state=ABSORB, ack=1.
  - f_ack and in_valid in the same FULL cycle: the input is not accepted. The source holds the word and it is accepted the following cycle.
- f_ack while in ABSORB is ignored.

Test Plan:
- Reset (W=64): hold rst 2 cycles -> out=0, out_ready=0, out_last=0, ack=1. Assert rst after 5 words of mode 01 -> counter cleared; an empty message then yields a padding-only block.
- Empty message, mode 01: one word with is_last=1, byte_num=0 -> next cycle out_ready=1, out_last=1, out[7:0]=8'h06, out[1087:1080]=8'h80, all other bits 0, ack=0 until f_ack.
- Partial word, mode 01: in=64'h0000000000AABBCC, is_last=1, byte_num=3 -> out[31:0]=32'h06AABBCC, out[63:32]=0, out[1087:1080]=8'h80.
- Multi-block, mode 01:
  - 17 full words with is_last=0 -> after word 17, out_ready=1, out_last=0, ack=0.
  - Pulse f_ack with in_valid high in the same cycle -> word not taken that cycle, taken the next.
  - A following is_last word with byte_num=0 -> second block with out[7:0]=8'h06, out[1087:1080]=8'h80, out_last=1.
- Merge boundary, mode 11:
  - 8 full words, then is_last with byte_num=7 and in=64'h0011223344556677.
  - Expect out[567:512]=56'h11223344556677, out[575:568]=8'h86, bits [1151:576]=0.
- Mode latch and W=32: instantiate with W=32; start mode 10, switch mode to 00 after word 1 -> block completes after 26 words (832-bit rate). After f_ack, a new message in mode 00 completes after 36 words.
